// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Pipeline hazard controller for the in-order RISC-V pipeline.
//            It tracks the in-flight destination registers (EX .. WB) and
//            drives the ID-stage stall, the multi-cycle flush after a
//            redirect and the operand-forwarding selects. It also keeps
//            saturating stall and flush event counters for on-board debug.
//            Optional feature macro: HAZARD_FORWARDING_EN
//              defined   -> forwarding; only load-use hazards stall.
//              undefined -> stall on any in-flight hazard; fwd tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       id_valid_i,
    input  logic [REG_ADDR_W-1:0]      id_rs1_i,
    input  logic [REG_ADDR_W-1:0]      id_rs2_i,
    input  logic                       id_use_rs1_i,
    input  logic                       id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0]      id_rd_i,
    input  logic                       id_we_i,
    input  logic                       id_is_load_i,
    input  logic                       redirect_i,
    output logic                       stall_o,
    output logic                       flush_o,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs1_o,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs2_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           flush_cnt_o
);

    localparam int FWD_W = $clog2(DEPTH+1);
    // Width of the remaining-flush-cycles counter (holds up to FLUSH_CYCLES-1).
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // Scoreboard: entry 0 is EX, entry DEPTH-1 is WB.
    logic [DEPTH-1:0]      r_v;
    logic [DEPTH-1:0]      r_ld;
    logic [REG_ADDR_W-1:0] r_rd [DEPTH];
    logic [FC_W-1:0]       r_fcnt;

    logic [DEPTH-1:0]      w_m1;
    logic [DEPTH-1:0]      w_m2;
    logic                  w_issue;

    // Per-entry source-operand match against the instruction sitting in ID.
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_m1[k] = r_v[k] && (r_rd[k] == id_rs1_i) && (id_rs1_i != '0)
                      && id_use_rs1_i && id_valid_i;
            w_m2[k] = r_v[k] && (r_rd[k] == id_rs2_i) && (id_rs2_i != '0)
                      && id_use_rs2_i && id_valid_i;
        end
    end

    assign flush_o = redirect_i | (r_fcnt != '0);
    assign w_issue = id_valid_i & ~stall_o & ~flush_o;

`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EX cannot be forwarded; everything else picks the
    // youngest matching producer (lowest entry index).
    always_comb begin
        stall_o   = ((w_m1[0] | w_m2[0]) & r_ld[0]) & ~flush_o;
        fwd_rs1_o = '0;
        fwd_rs2_o = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (w_m1[k]) fwd_rs1_o = FWD_W'(k+1);
            if (w_m2[k]) fwd_rs2_o = FWD_W'(k+1);
        end
        if (stall_o) begin
            fwd_rs1_o = '0;
            fwd_rs2_o = '0;
        end
    end
`else
    logic w_unused_ld;

    // Without forwarding, any in-flight producer of a source holds ID.
    always_comb begin
        stall_o   = ((|w_m1) | (|w_m2)) & ~flush_o;
        fwd_rs1_o = '0;
        fwd_rs2_o = '0;
    end

    // The load flag only matters when forwarding is built in.
    assign w_unused_ld = ^{r_ld, id_is_load_i};
`endif

    // Shift the scoreboard each cycle; a stalled, flushed or empty ID slot
    // enters EX as a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int k = 0; k < DEPTH; k++) r_rd[k] <= '0;
        end else begin
            for (int k = DEPTH-1; k > 0; k--) begin
                r_v[k]  <= r_v[k-1];
                r_ld[k] <= r_ld[k-1];
                r_rd[k] <= r_rd[k-1];
            end
            r_v[0]  <= w_issue & id_we_i & (id_rd_i != '0);
            r_ld[0] <= id_is_load_i;
            r_rd[0] <= id_rd_i;
        end
    end

    // Flush sequencer: a redirect (re)loads the remaining-cycle count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fcnt <= '0;
        end else if (redirect_i) begin
            r_fcnt <= FC_W'(FLUSH_CYCLES-1);
        end else if (r_fcnt != '0) begin
            r_fcnt <= r_fcnt - 1'b1;
        end
    end

    // Saturating debug counters for stall cycles and redirect events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (redirect_i && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard: directed pipeline
//            scenarios plus randomized traffic against a queue-based model.
//            A second instance with 3-bit counters exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int FC    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0;
    logic       id_we = 1'b0, id_ld = 1'b0, redirect = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic        stall, flush;
    logic [1:0]  fwd1, fwd2;
    logic [15:0] scnt, fcnt;
    logic        s_unused_stall, s_unused_flush;
    logic [1:0]  s_unused_fwd1, s_unused_fwd2;
    logic [2:0]  s_scnt, s_fcnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
        .id_rs2_i(id_rs2), .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_is_load_i(id_ld),
        .redirect_i(redirect), .stall_o(stall), .flush_o(flush),
        .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2), .stall_cnt_o(scnt), .flush_cnt_o(fcnt));

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(3)) dut_small (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
        .id_rs2_i(id_rs2), .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_is_load_i(id_ld),
        .redirect_i(redirect), .stall_o(s_unused_stall), .flush_o(s_unused_flush),
        .fwd_rs1_o(s_unused_fwd1), .fwd_rs2_o(s_unused_fwd2),
        .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the last DEPTH things that left ID (newest first).
    typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
    ent_t sb[$];
    int   fleft;
    int   m_scnt, m_fcnt, m_scnt_s, m_fcnt_s;

    function automatic void model_reset();
        ent_t b;
        b = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
        sb.delete();
        for (int i = 0; i < DEPTH; i++) sb.push_back(b);
        fleft = 0;
        m_scnt = 0; m_fcnt = 0; m_scnt_s = 0; m_fcnt_s = 0;
    endfunction

    function automatic bit hit(input int k, input logic [4:0] rs, input logic use_rs);
        return id_valid && use_rs && (rs != 0) && sb[k].v && (sb[k].rd == rs);
    endfunction

    function automatic int first_hit(input logic [4:0] rs, input logic use_rs);
        for (int k = 0; k < DEPTH; k++) if (hit(k, rs, use_rs)) return k + 1;
        return 0;
    endfunction

    // Check one cycle's outputs against the model, then advance both.
    task automatic step();
        bit   e_flush, e_stall, any;
        int   e_f1, e_f2;
        ent_t n;
        #1;
        e_flush = redirect || (fleft > 0);
        any = 1'b0;
        for (int k = 0; k < DEPTH; k++) any |= hit(k, id_rs1, id_use1) | hit(k, id_rs2, id_use2);
`ifdef HAZARD_FORWARDING_EN
        e_stall = (hit(0, id_rs1, id_use1) || hit(0, id_rs2, id_use2)) && sb[0].ld;
        e_f1 = first_hit(id_rs1, id_use1);
        e_f2 = first_hit(id_rs2, id_use2);
`else
        e_stall = any;
        e_f1 = 0;
        e_f2 = 0;
`endif
        if (e_flush) e_stall = 1'b0;
        if (e_stall) begin e_f1 = 0; e_f2 = 0; end
        chk("stall", stall, e_stall);
        chk("flush", flush, e_flush);
        chk("fwd_rs1", fwd1, e_f1);
        chk("fwd_rs2", fwd2, e_f2);
        chk("stall_cnt", scnt, m_scnt);
        chk("flush_cnt", fcnt, m_fcnt);
        chk("stall_cnt_sat", s_scnt, m_scnt_s);
        chk("flush_cnt_sat", s_fcnt, m_fcnt_s);
        @(posedge clk);
        if (e_stall) begin
            if (m_scnt < 65535) m_scnt++;
            if (m_scnt_s < 7) m_scnt_s++;
        end
        if (redirect) begin
            if (m_fcnt < 65535) m_fcnt++;
            if (m_fcnt_s < 7) m_fcnt_s++;
            fleft = FC - 1;
        end else if (fleft > 0) begin
            fleft--;
        end
        if (id_valid && !e_stall && !e_flush)
            n = '{v: id_we && (id_rd != 0), rd: id_rd, ld: id_ld};
        else
            n = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
        sb.push_front(n);
        void'(sb.pop_back());
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic rdr);
        id_valid = v; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
        id_rd = rd; id_we = we; id_ld = ld; redirect = rdr;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Reset state.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // addi x5 ; add x6,x5,x5
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step();
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
        repeat (4) step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
`ifdef HAZARD_FORWARDING_EN
        chk("stall_cnt_dir", scnt, 0);
`else
        chk("stall_cnt_dir", scnt, 3);
`endif

        // lw x7 ; add x8,x7,x0
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step();
        drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
        repeat (4) step();

        // Single redirect, then a redirect landing on the second flush cycle.
        drive(1, 0, 0, 0, 0, 9, 1, 0, 1);
        step();
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
        repeat (2) step();
        chk("flush_cnt_dir1", fcnt, 1);
        drive(1, 0, 0, 0, 0, 9, 1, 0, 1);
        step();
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        repeat (3) step();
        chk("flush_cnt_dir2", fcnt, 3);

        // x0 writes and unused sources never stall or forward.
        drive(1, 0, 1, 0, 1, 0, 1, 1, 0);
        step();
        drive(1, 3, 0, 3, 0, 3, 1, 1, 0);
        step();
        drive(1, 3, 0, 3, 0, 4, 1, 0, 0);
        repeat (2) step();

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            if (i == 1000) begin
                redirect = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_stall", stall, 0);
                chk("rst_flush", flush, 0);
                chk("rst_fwd", {fwd1, fwd2}, 0);
                chk("rst_cnt", {scnt, fcnt}, 0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
